// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and load/store, streaming bytes little-endian.
// Optional MEM_CTRL_RR_EN selects round-robin IF/MEM arbitration; the default build gives MEM fixed priority.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mem_size,
  input  logic                  mem_sext,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CNT_WIDTH  = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  cnt_n;
  logic [CNT_WIDTH-1:0]  j;
  logic                  we_q;
  logic                  sext_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  if_done_q;

  logic                  if_ok_c;
  logic                  mem_win_c;
  logic                  grant_mem;
  logic                  grant_if;
  logic                  flush_c;
  logic                  last_c;
  logic [CNT_WIDTH-1:0]  j_next_c;
  logic [CNT_WIDTH-1:0]  mem_n_c;
  logic [ADDR_WIDTH-1:0] start_addr_c;
  logic [DATA_WIDTH-1:0] word_c;
  logic [DATA_WIDTH-1:0] ext_c;

  // A fetch redirected in the same cycle is never started.
  assign if_ok_c = if_req & ~if_flush;

`ifdef MEM_CTRL_RR_EN
  logic last_mem;

  // On a tie, grant whichever side did not win the previous grant.
  always_comb begin
    mem_win_c = mem_req & (~if_ok_c | ~last_mem);
  end
`else
  always_comb begin
    mem_win_c = mem_req;
  end
`endif

  assign flush_c      = (owner == OWN_IF) & if_flush;
  assign j_next_c     = j + CNT_WIDTH'(1);
  assign start_addr_c = grant_mem ? mem_addr : if_addr;
  assign last_c       = we_q ? (j == cnt_n - CNT_WIDTH'(1)) : (j == cnt_n);

  always_comb begin
    case (mem_size)
      2'b00:   mem_n_c = CNT_WIDTH'(1);
      2'b01:   mem_n_c = CNT_WIDTH'(2);
      default: mem_n_c = CNT_WIDTH'(4);
    endcase
  end

  // Merge the byte arriving this cycle (issued last cycle) into the assembly buffer.
  always_comb begin
    word_c = data_q;
    case (j)
      3'd1:    word_c[7:0]   = ram_din;
      3'd2:    word_c[15:8]  = ram_din;
      3'd3:    word_c[23:16] = ram_din;
      3'd4:    word_c[31:24] = ram_din;
      default: ;
    endcase
  end

  always_comb begin
    case (cnt_n)
      3'd1:    ext_c = {{24{sext_q & word_c[7]}}, word_c[7:0]};
      3'd2:    ext_c = {{16{sext_q & word_c[15]}}, word_c[15:0]};
      default: ext_c = word_c;
    endcase
  end

  always_comb begin
    next_state = state;
    grant_mem  = 1'b0;
    grant_if   = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_win_c) begin
          grant_mem  = 1'b1;
          next_state = S_BUSY;
        end else if (if_ok_c) begin
          grant_if   = 1'b1;
          next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush_c) begin
          next_state = S_IDLE;
        end else if (last_c) begin
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_IF;
      addr_q    <= '0;
      cnt_n     <= '0;
      j         <= '0;
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      wdata_q   <= '0;
      data_q    <= '0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
      if_inst   <= '0;
      mem_rdata <= '0;
      if_done_q <= 1'b0;
      mem_done  <= 1'b0;
`ifdef MEM_CTRL_RR_EN
      last_mem  <= 1'b0;
`endif
    end else begin
      ram_wr    <= 1'b0;
      if_done_q <= 1'b0;
      mem_done  <= 1'b0;

      // Grant: latch the request and present byte 0 in the first BUSY cycle.
      if (grant_mem | grant_if) begin
        owner    <= grant_mem;
        addr_q   <= start_addr_c;
        cnt_n    <= grant_mem ? mem_n_c : CNT_WIDTH'(4);
        we_q     <= grant_mem & mem_we;
        sext_q   <= grant_mem & mem_sext;
        wdata_q  <= mem_wdata;
        j        <= '0;
        ram_a    <= start_addr_c;
        ram_wr   <= grant_mem & mem_we;
        ram_dout <= mem_wdata[7:0];
`ifdef MEM_CTRL_RR_EN
        last_mem <= grant_mem;
`endif
      end

      if (state == S_BUSY) begin
        if (!we_q) begin
          data_q <= word_c;
        end
        if (next_state == S_BUSY) begin
          j        <= j_next_c;
          ram_a    <= addr_q + ADDR_WIDTH'(j_next_c);
          ram_wr   <= we_q;
          ram_dout <= 8'(wdata_q >> {j_next_c[1:0], 3'b000});
        end else if (next_state == S_DONE) begin
          if (owner == OWN_MEM) begin
            mem_done <= 1'b1;
            if (!we_q) begin
              mem_rdata <= ext_c;
            end
          end else begin
            if_done_q <= 1'b1;
            if_inst   <= word_c;
          end
        end
      end
    end
  end

  // A redirect arriving in the completion cycle suppresses the pulse only; the instruction still lands.
  assign if_done = if_done_q & ~if_flush;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, hand-written corner sequences and
// randomized single-requester traffic checked against a byte-array reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [1:0]  mem_size = '0;
  logic        mem_sext = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_sext(mem_sext), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy), .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // RAM driven by the DUT (1-cycle read latency) and the bench's own expected image.
  logic [7:0] ram   [0:1023];
  logic [7:0] model [0:1023];

  always @(posedge clk) begin
    ram_din <= ram[ram_a[9:0]];
    if (ram_wr) ram[ram_a[9:0]] = ram_dout;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] last_load = '0;
  logic [31:0] last_inst = '0;
  bit last_grant_mem = 1'b0;
`ifdef MEM_CTRL_RR_EN
  bit rr = 1'b1;
`else
  bit rr = 1'b0;
`endif

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n, input bit sext);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) w = w | (32'(model[10'(addr + 32'(i))]) << (8 * i));
    if (sext && n == 1 && w[7])  w = w | 32'hFFFFFF00;
    if (sext && n == 2 && w[15]) w = w | 32'hFFFF0000;
    return w;
  endfunction

  task automatic model_store(input logic [31:0] addr, input int n, input logic [31:0] wdata);
    for (int i = 0; i < n; i++) model[10'(addr + 32'(i))] = 8'(wdata >> (8 * i));
  endtask

  // One single-requester transaction, started from a falling edge in IDLE; checks the byte
  // stream cycle by cycle, latency, result and the held value of the other result register.
  task automatic run_xact(input bit is_if, input bit we, input logic [31:0] addr, input logic [1:0] size,
                          input bit sext, input logic [31:0] wdata, input logic [31:0] exp,
                          input int lat, input string name);
    int n;
    int c;
    bit seen;
    bit st;
    n = is_if ? 4 : nbytes(size);
    st = we && !is_if;
    c = 0;
    seen = 1'b0;
    if (is_if) begin
      if_addr = addr; if_req = 1'b1;
    end else begin
      mem_addr = addr; mem_we = we; mem_size = size; mem_sext = sext; mem_wdata = wdata; mem_req = 1'b1;
    end
    while (!seen && c < 30) begin
      @(negedge clk);
      c++;
      if (c <= n) begin
        chk({name, " ram_a"}, ram_a, addr + 32'(c - 1));
        chk({name, " ram_wr"}, 32'(ram_wr), 32'(st));
        if (st) chk({name, " ram_dout"}, 32'(ram_dout), (wdata >> (8 * (c - 1))) & 32'hFF);
      end else begin
        chk({name, " ram_wr idle"}, 32'(ram_wr), 32'd0);
      end
      chk({name, " busy"}, 32'(busy), 32'd1);
      if (if_done || mem_done) begin
        seen = 1'b1;
        chk({name, " latency"}, 32'(c), 32'(lat));
        chk({name, " done owner"}, {30'd0, if_done, mem_done}, is_if ? 32'd2 : 32'd1);
        if (is_if) begin
          chk({name, " if_inst"}, if_inst, exp);
          chk({name, " mem_rdata held"}, mem_rdata, last_load);
        end else if (we) begin
          chk({name, " mem_rdata held"}, mem_rdata, last_load);
          chk({name, " if_inst held"}, if_inst, last_inst);
        end else begin
          chk({name, " mem_rdata"}, mem_rdata, exp);
          chk({name, " if_inst held"}, if_inst, last_inst);
        end
        if_req = 1'b0;
        mem_req = 1'b0;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no done expected done in cycle %0d", name, lat);
      if_req = 1'b0; mem_req = 1'b0;
    end
    if (st) model_store(addr, n, wdata);
    else if (is_if) last_inst = exp;
    else last_load = exp;
    last_grant_mem = !is_if;
    @(negedge clk);
    chk({name, " back to idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int md;
    int id;
    int c;
    int mism;
    bit mem_first;
    bit saw;

    for (int i = 0; i < 1024; i++) begin ram[i] = 8'h00; model[i] = 8'h00; end
    ram[10'h000] = 8'h13; ram[10'h001] = 8'h05;
    ram[10'h010] = 8'h78; ram[10'h011] = 8'h56; ram[10'h012] = 8'h34; ram[10'h013] = 8'h12;
    ram[10'h020] = 8'h80; ram[10'h030] = 8'h34; ram[10'h031] = 8'h92;
    ram[10'h043] = 8'h5A; ram[10'h3FE] = 8'hAA; ram[10'h3FF] = 8'h01;
    for (int i = 0; i < 1024; i++) model[i] = ram[i];

    //        is_if we    addr            size   sext  wdata          expected       lat
    vt[0]  = '{1'b1, 1'b0, 32'h0000_0000, 2'd2, 1'b0, 32'h0,         32'h0000_0513, 6};
    vt[1]  = '{1'b0, 1'b0, 32'h0000_0020, 2'd0, 1'b1, 32'h0,         32'hFFFF_FF80, 3};
    vt[2]  = '{1'b0, 1'b0, 32'h0000_0020, 2'd0, 1'b0, 32'h0,         32'h0000_0080, 3};
    vt[3]  = '{1'b0, 1'b0, 32'h0000_0030, 2'd1, 1'b1, 32'h0,         32'hFFFF_9234, 4};
    vt[4]  = '{1'b0, 1'b0, 32'h0000_0030, 2'd1, 1'b0, 32'h0,         32'h0000_9234, 4};
    vt[5]  = '{1'b0, 1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0,         32'h1234_5678, 6};
    vt[6]  = '{1'b0, 1'b1, 32'h0000_0041, 2'd1, 1'b0, 32'hDEAD_BEEF, 32'h0,         3};
    vt[7]  = '{1'b0, 1'b0, 32'h0000_0041, 2'd3, 1'b1, 32'h0,         32'h005A_BEEF, 6};
    vt[8]  = '{1'b0, 1'b1, 32'h0000_0050, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0,         5};
    vt[9]  = '{1'b0, 1'b0, 32'h0000_0050, 2'd2, 1'b0, 32'h0,         32'hCAFE_F00D, 6};
    vt[10] = '{1'b0, 1'b1, 32'h0000_0060, 2'd0, 1'b0, 32'h1234_56A5, 32'h0,         2};
    vt[11] = '{1'b0, 1'b0, 32'h0000_0060, 2'd0, 1'b0, 32'h0,         32'h0000_00A5, 3};
    vt[12] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 2'd2, 1'b0, 32'h0,         32'h0513_01AA, 6};
    vt[13] = '{1'b0, 1'b0, 32'h0000_0031, 2'd0, 1'b1, 32'h0,         32'hFFFF_FF92, 3};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ram_wr", 32'(ram_wr), 32'd0);
    chk("reset ram_a", ram_a, 32'd0);
    chk("reset ram_dout", 32'(ram_dout), 32'd0);
    chk("reset if_inst", if_inst, 32'd0);
    chk("reset mem_rdata", mem_rdata, 32'd0);
    chk("reset dones", {30'd0, if_done, mem_done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      run_xact(vt[i].is_if, vt[i].we, vt[i].addr, vt[i].size, vt[i].sext, vt[i].wdata,
               vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));
    chk("SH left 0x43", 32'(ram[10'h043]), 32'h5A);
    chk("SH left 0x40", 32'(ram[10'h040]), 32'h00);
    chk("SH wrote 0x42", 32'(ram[10'h042]), 32'hBE);

    // Contention: both requests raised in the same IDLE cycle
    mem_first = rr ? !last_grant_mem : 1'b1;
    if_addr = 32'h0; if_req = 1'b1;
    mem_addr = 32'h10; mem_we = 1'b0; mem_size = 2'd2; mem_sext = 1'b0; mem_req = 1'b1;
    md = 0; id = 0; c = 0;
    while ((md == 0 || id == 0) && c < 30) begin
      @(negedge clk);
      c++;
      if (mem_done) begin md = c; mem_req = 1'b0; chk("contend mem_rdata", mem_rdata, 32'h1234_5678); end
      if (if_done)  begin id = c; if_req = 1'b0;  chk("contend if_inst", if_inst, 32'h0000_0513); end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("contend mem_done cycle", 32'(md), mem_first ? 32'd6 : 32'd13);
    chk("contend if_done cycle", 32'(id), mem_first ? 32'd13 : 32'd6);
    last_load = 32'h1234_5678; last_inst = 32'h0000_0513; last_grant_mem = !mem_first;
    @(negedge clk);

    // MEM request arriving while a fetch is in flight waits for the fetch
    if_addr = 32'h10; if_req = 1'b1;
    md = 0; id = 0; c = 0;
    while ((md == 0 || id == 0) && c < 30) begin
      @(negedge clk);
      c++;
      if (mem_done) begin md = c; mem_req = 1'b0; end
      if (if_done)  begin id = c; if_req = 1'b0; chk("late mem if_inst", if_inst, 32'h1234_5678); end
      if (c == 2) begin
        mem_addr = 32'h70; mem_we = 1'b1; mem_size = 2'd0; mem_wdata = 32'h0000_005C; mem_req = 1'b1;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("late mem if_done cycle", 32'(id), 32'd6);
    chk("late mem mem_done cycle", 32'(md), 32'd9);
    model_store(32'h70, 1, 32'h5C);
    last_inst = 32'h1234_5678; last_grant_mem = 1'b1;
    @(negedge clk);

    // Flush in BUSY cancels the fetch without a pulse
    if_addr = 32'h8; if_req = 1'b1;
    saw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (if_done) saw = 1'b1;
      if (k == 2) if_flush = 1'b1;
      if (k == 3) begin
        if_flush = 1'b0; if_req = 1'b0;
        chk("flush busy idle", 32'(busy), 32'd0);
      end
    end
    chk("flush no if_done", 32'(saw), 32'd0);
    chk("flush if_inst kept", if_inst, last_inst);
    run_xact(1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, model_load(32'h40, 4, 1'b0), 6, "refetch");

    // Flush in the completion cycle gates the pulse but the instruction still lands
    if_addr = 32'h50; if_req = 1'b1;
    saw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        if_flush = 1'b1;
        #1;
        chk("done flush busy", 32'(busy), 32'd1);
        if_req = 1'b0;
      end
      if (if_done) saw = 1'b1;
      if (k == 7) begin
        if_flush = 1'b0;
        chk("done flush if_inst", if_inst, 32'hCAFE_F00D);
        chk("done flush idle", 32'(busy), 32'd0);
      end
    end
    chk("done flush no if_done", 32'(saw), 32'd0);
    last_inst = 32'hCAFE_F00D; last_grant_mem = 1'b0;

    // Reset in the middle of a word store
    mem_addr = 32'h100; mem_we = 1'b1; mem_size = 2'd2; mem_wdata = 32'h1122_3344; mem_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst ram_wr", 32'(ram_wr), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst mem_done", 32'(mem_done), 32'd0);
    chk("midrst ram_a", ram_a, 32'd0);
    chk("midrst if_inst", if_inst, 32'd0);
    chk("midrst mem_rdata", mem_rdata, 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst outputs", {ram_a[7:0], ram_dout, 13'd0, ram_wr, busy, mem_done}, 32'd0);
    model[10'h100] = 8'h44; model[10'h101] = 8'h33;
    last_load = '0; last_inst = '0; last_grant_mem = 1'b0;

    // Randomized single-requester traffic
    for (int t = 0; t < 60; t++) begin
      bit r_if;
      bit r_we;
      logic [31:0] r_addr;
      logic [1:0] r_size;
      bit r_sext;
      logic [31:0] r_wdata;
      int n;
      r_if    = ($urandom_range(0, 3) == 0);
      r_we    = !r_if && ($urandom_range(0, 1) == 1);
      r_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                            : 32'($urandom_range(0, 1023));
      r_size  = 2'($urandom_range(0, 3));
      r_sext  = ($urandom_range(0, 1) == 1);
      r_wdata = $urandom;
      n = r_if ? 4 : nbytes(r_size);
      run_xact(r_if, r_we, r_addr, r_size, r_sext, r_wdata,
               r_we ? 32'h0 : model_load(r_addr, n, r_sext && !r_if),
               r_we ? n + 1 : n + 2, $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== model[i]) mism++;
    chk("ram image bytes differing", 32'(mism), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
